// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the Keccak-f[1600] datapath: load strobe, per-round strobe and one-hot
// round select, and a done/ready handshake back to the host.
module keccak_round_ctrl #(
  parameter int NROUNDS      = 24,
  parameter int ROUND_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        ready,
  input  logic        abort,
  output logic        load_en,
  output logic        round_en,
  output logic [23:0] round_onehot,
  output logic [4:0]  round_idx,
  output logic        busy,
  output logic        done_valid,
  input  logic        done_ready
);

  localparam int SW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(ROUND_CYCLES - 1);
  localparam logic [4:0]    RND_LAST = 5'(NROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   sub_r, sub_s;
  logic [4:0]      round_r, round_s;
  logic            round_en_s;
  logic [23:0]     onehot_s;
  logic [4:0]      idx_s;

  // Next-state and counter logic; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    sub_s   = sub_r;
    round_s = round_r;
    if (abort) begin
      state_s = S_IDLE;
      sub_s   = '0;
      round_s = 5'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_s = S_LOAD;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LOAD: begin
          state_s = S_ROUND;
          sub_s   = '0;
          round_s = 5'd0;
        end
        S_ROUND: begin
          if (sub_r == SUB_LAST) begin
            sub_s = '0;
            if (round_r == RND_LAST) begin
              state_s = S_DONE;
              round_s = 5'd0;
            end else begin
              round_s = round_r + 5'd1;
            end
          end else begin
            sub_s = sub_r + SW'(1);
          end
        end
        S_DONE: begin
          if (done_ready) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DONE;
          end
        end
        default: begin
          state_s = S_IDLE;
          sub_s   = '0;
          round_s = 5'd0;
        end
      endcase
    end
  end

  // Output decode of the next state, so the registered outputs track the state register exactly.
  always_comb begin
    round_en_s = 1'b0;
    onehot_s   = 24'd0;
    idx_s      = 5'd0;
    if (state_s == S_ROUND) begin
      round_en_s = (sub_s == SUB_LAST);
      onehot_s   = 24'd1 << round_s;
      idx_s      = round_s;
    end else begin
      round_en_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      sub_r        <= '0;
      round_r      <= 5'd0;
      ready        <= 1'b1;
      load_en      <= 1'b0;
      round_en     <= 1'b0;
      round_onehot <= 24'd0;
      round_idx    <= 5'd0;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
    end else begin
      state_r      <= state_s;
      sub_r        <= sub_s;
      round_r      <= round_s;
      ready        <= (state_s == S_IDLE);
      load_en      <= (state_s == S_LOAD);
      round_en     <= round_en_s;
      round_onehot <= onehot_s;
      round_idx    <= idx_s;
      busy         <= (state_s == S_LOAD) || (state_s == S_ROUND);
      done_valid   <= (state_s == S_DONE);
    end
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: three instances (24x1, 24x3, 1x1 rounds x cycles),
// the stimulus process queues expected strobes and snapshots, a monitor pops and compares them.
module tb_keccak_round_ctrl;

  localparam int K_LOAD  = 0;
  localparam int K_ROUND = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [23:0] oh;
  } ev_t;

  typedef struct {
    int          cyc;
    string       name;
    logic        ready;
    logic        busy;
    logic        dv;
    logic [23:0] oh;
    logic [4:0]  idx;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, done_ready;
  int   sel;
  int   cyc = 0;

  logic [2:0]  start_w, ready_w, load_w, round_w, busy_w, dv_w;
  logic [23:0] oh_w [3];
  logic [4:0]  idx_w [3];

  ev_t   eq[$];
  snap_t sq[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  fin = 1'b0;
  logic  fin_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_w[0] = start && (sel == 0);
  assign start_w[1] = start && (sel == 1);
  assign start_w[2] = start && (sel == 2);

  keccak_round_ctrl #(.NROUNDS(24), .ROUND_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .ready(ready_w[0]), .abort(abort),
    .load_en(load_w[0]), .round_en(round_w[0]), .round_onehot(oh_w[0]), .round_idx(idx_w[0]),
    .busy(busy_w[0]), .done_valid(dv_w[0]), .done_ready(done_ready));

  keccak_round_ctrl #(.NROUNDS(24), .ROUND_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .ready(ready_w[1]), .abort(abort),
    .load_en(load_w[1]), .round_en(round_w[1]), .round_onehot(oh_w[1]), .round_idx(idx_w[1]),
    .busy(busy_w[1]), .done_valid(dv_w[1]), .done_ready(done_ready));

  keccak_round_ctrl #(.NROUNDS(1), .ROUND_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .ready(ready_w[2]), .abort(abort),
    .load_en(load_w[2]), .round_en(round_w[2]), .round_onehot(oh_w[2]), .round_idx(idx_w[2]),
    .busy(busy_w[2]), .done_valid(dv_w[2]), .done_ready(done_ready));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input int k, input logic [23:0] oh);
    ev_t e;
    e.cyc = c; e.kind = k; e.oh = oh;
    eq.push_back(e);
  endtask

  task automatic push_snap(input int c, input string nm, input logic rdy, input logic bsy,
                           input logic dv, input logic [23:0] oh, input logic [4:0] idx);
    snap_t s;
    s.cyc = c; s.name = nm; s.ready = rdy; s.busy = bsy; s.dv = dv; s.oh = oh; s.idx = idx;
    sq.push_back(s);
  endtask

  // Queue the strobes of a whole permutation whose start is sampled at the end of cycle s.
  task automatic expect_perm(input int s, input int nr, input int rc, input int upto);
    logic [23:0] one;
    one = 24'd1;
    push_ev(s + 1, K_LOAD, 24'd0);
    for (int k = 0; k < upto; k++) push_ev(s + 2 + k * rc + rc - 1, K_ROUND, one << k);
    if (upto == nr) push_ev(s + 2 + nr * rc, K_DONE, 24'd0);
  endtask

  // Monitor: pops an expected event whenever the selected DUT strobes, checks due snapshots.
  initial begin
    logic        m_ready, m_load, m_round, m_busy, m_dv, prev_dv;
    logic [23:0] m_oh;
    logic [4:0]  m_idx;
    int          kind;
    ev_t         e;
    snap_t       s;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      m_ready = ready_w[sel]; m_load = load_w[sel]; m_round = round_w[sel];
      m_busy = busy_w[sel]; m_dv = dv_w[sel]; m_oh = oh_w[sel]; m_idx = idx_w[sel];
      kind = -1;
      if (m_load) kind = K_LOAD;
      else if (m_round) kind = K_ROUND;
      else if (m_dv && !prev_dv) kind = K_DONE;
      prev_dv = m_dv;
      if (kind >= 0) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
          e = eq.pop_front();
          if (e.kind != kind || e.cyc != cyc || (kind == K_ROUND && e.oh != m_oh)) begin
            n_err++;
            $display("FAIL strobe: got kind %0d cycle %0d onehot %h, expected kind %0d cycle %0d onehot %h",
                     kind, cyc, m_oh, e.kind, e.cyc, e.oh);
          end
        end
      end
      while (sq.size() != 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        n_vec++;
        if (s.cyc != cyc || m_ready !== s.ready || m_busy !== s.busy || m_dv !== s.dv ||
            m_oh !== s.oh || m_idx !== s.idx) begin
          n_err++;
          $display("FAIL %s: cycle %0d ready/busy/dv/onehot/idx = %b/%b/%b/%h/%0d, expected cycle %0d %b/%b/%b/%h/%0d",
                   s.name, cyc, m_ready, m_busy, m_dv, m_oh, m_idx, s.cyc, s.ready, s.busy, s.dv, s.oh, s.idx);
        end
      end
      if (fin && !fin_done) begin
        n_vec++;
        if (eq.size() != 0 || sq.size() != 0) begin
          n_err++;
          $display("FAIL leftover: %0d strobes and %0d snapshots never observed, expected 0",
                   eq.size(), sq.size());
        end
        fin_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; done_ready = 1'b0; sel = 0;
    tick(3);
    push_snap(cyc, "reset_vals", 1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // T1 + T3: full run, then done held with start kept high.
    s = cyc; start = 1'b1;
    expect_perm(s, 24, 1, 24);
    push_snap(s + 1,  "t1_load",    1'b0, 1'b1, 1'b0, 24'd0, 5'd0);
    push_snap(s + 2,  "t1_round0",  1'b0, 1'b1, 1'b0, 24'h000001, 5'd0);
    push_snap(s + 25, "t1_round23", 1'b0, 1'b1, 1'b0, 24'h800000, 5'd23);
    push_snap(s + 26, "t1_done",    1'b0, 1'b0, 1'b1, 24'd0, 5'd0);
    push_snap(s + 28, "t3_hold_a",  1'b0, 1'b0, 1'b1, 24'd0, 5'd0);
    push_snap(s + 30, "t3_hold_b",  1'b0, 1'b0, 1'b1, 24'd0, 5'd0);
    push_snap(s + 32, "t3_idle",    1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(31);
    done_ready = 1'b1;
    tick(1);
    done_ready = 1'b0;
    expect_perm(s + 32, 24, 1, 24);
    tick(1);
    start = 1'b0;
    tick(25);
    done_ready = 1'b1;
    push_snap(s + 59, "t3_idle2", 1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(1);
    done_ready = 1'b0;
    tick(2);

    // T2: three clocks per round.
    sel = 1;
    tick(1);
    s = cyc; start = 1'b1;
    expect_perm(s, 24, 3, 24);
    push_snap(s + 2,  "t2_r0_first", 1'b0, 1'b1, 1'b0, 24'h000001, 5'd0);
    push_snap(s + 4,  "t2_r0_last",  1'b0, 1'b1, 1'b0, 24'h000001, 5'd0);
    push_snap(s + 5,  "t2_r1",       1'b0, 1'b1, 1'b0, 24'h000002, 5'd1);
    push_snap(s + 74, "t2_done",     1'b0, 1'b0, 1'b1, 24'd0, 5'd0);
    tick(1);
    start = 1'b0;
    tick(73);
    done_ready = 1'b1;
    tick(1);
    done_ready = 1'b0;
    tick(2);

    // T4: abort during round 10, then a clean run.
    sel = 0;
    tick(1);
    s = cyc; start = 1'b1;
    expect_perm(s, 24, 1, 11);
    push_snap(s + 12, "t4_abort_cyc", 1'b0, 1'b1, 1'b0, 24'h000400, 5'd10);
    push_snap(s + 13, "t4_after",     1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(1);
    start = 1'b0;
    tick(11);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(5);
    s = cyc; start = 1'b1;
    expect_perm(s, 24, 1, 24);
    tick(1);
    start = 1'b0;
    tick(25);
    done_ready = 1'b1;
    tick(1);
    done_ready = 1'b0;
    tick(2);

    // T5: async reset in the middle of round 7.
    s = cyc; start = 1'b1;
    expect_perm(s, 24, 1, 7);
    push_snap(s + 9, "t5_in_reset", 1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    push_snap(s + 20, "t5_idle",    1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(1);
    start = 1'b0;
    tick(8);
    #2;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(30);

    // T6: single-round permutation, then start+abort together in IDLE.
    sel = 2;
    tick(1);
    s = cyc; start = 1'b1;
    expect_perm(s, 1, 1, 1);
    push_snap(s + 2, "t6_round", 1'b0, 1'b1, 1'b0, 24'h000001, 5'd0);
    push_snap(s + 3, "t6_done",  1'b0, 1'b0, 1'b1, 24'd0, 5'd0);
    tick(1);
    start = 1'b0;
    tick(2);
    done_ready = 1'b1;
    tick(1);
    done_ready = 1'b0;
    start = 1'b1; abort = 1'b1;
    push_snap(cyc + 1, "t6_start_abort", 1'b1, 1'b0, 1'b0, 24'd0, 5'd0);
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(4);

    fin = 1'b1;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
